// File: rtl/cpu_types_pkg.sv
// Shared types for the multi-core request unit.
// Holds the per-core request state enum and the select-width helper.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        GRANT = 2'd2
    } ru_state_t;

    // Width of a core index; a single core still gets a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_request_unit_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting core at or above the
// pointer, wrapping around. Purely combinational.
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter  int NCH  = 2,
    localparam int SELW = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] idx
);

    int   cand;
    logic found;

    // Scan from the pointer upward with wrap; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NCH; i++) begin
            cand = (int'(ptr) + i) % NCH;
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = SELW'(cand);
            end
        end
    end

endmodule

// File: rtl/multi_request_unit.sv
// Multi-core data request unit. Latches each core's load/store request on
// its instruction hit, holds it until the shared data port returns a hit,
// and round-robin arbitrates pending requests onto that single port.
// Optional feature macro: RU_WATCHDOG_EN (sticky grant-timeout flag).
module multi_request_unit
    import cpu_types_pkg::*;
#(
    parameter  int NCH      = 2,
    parameter  int WD_LIMIT = 1024,
    localparam int SELW     = sel_width(NCH)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NCH-1:0]  ihit,
    input  logic [NCH-1:0]  Mem_Read,
    input  logic [NCH-1:0]  Mem_Write,
    input  logic [NCH-1:0]  halt,
    input  logic            dport_hit,
    output logic [NCH-1:0]  dhit,
    output logic [NCH-1:0]  dmemREN,
    output logic [NCH-1:0]  dmemWEN,
    output logic [NCH-1:0]  imemREN,
    output logic            dport_ren,
    output logic            dport_wen,
    output logic [SELW-1:0] dport_sel,
    output logic            wd_err
);

    if (NCH < 1 || WD_LIMIT < 1) begin : g_param_check
        $error("multi_request_unit: NCH and WD_LIMIT must both be at least 1");
    end

    ru_state_t       state [NCH];
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] sel;
    logic [NCH-1:0]  ren;
    logic [NCH-1:0]  wen;
    logic [NCH-1:0]  pend;
    logic [NCH-1:0]  new_req;
    logic            any_grant;
    logic [NCH-1:0]  arb_gnt;
    logic [SELW-1:0] arb_idx;
    logic [SELW-1:0] ptr_next;

    // Decode per-core pending flags, the single-grant flag and new requests.
    always_comb begin
        pend      = '0;
        any_grant = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            pend[c] = (state[c] == PEND);
            if (state[c] == GRANT) any_grant = 1'b1;
        end
        new_req = ihit & (Mem_Read | Mem_Write) & ~halt;
    end

    // The arbiter only picks while the port is free.
    rr_arbiter #(.NCH(NCH)) u_arb (
        .req (pend),
        .ptr (ptr),
        .en  (!any_grant),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign ptr_next = (sel == SELW'(NCH - 1)) ? '0 : sel + 1'b1;

    // Per-core request state, latched enables, grant index and RR pointer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < NCH; c++) state[c] <= IDLE;
            ren <= '0;
            wen <= '0;
            ptr <= '0;
            sel <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                case (state[c])
                    IDLE: begin
                        if (new_req[c]) begin
                            state[c] <= PEND;
                            wen[c]   <= Mem_Write[c];
                            ren[c]   <= Mem_Read[c] && !Mem_Write[c];
                        end
                    end
                    PEND: begin
                        if (arb_gnt[c]) state[c] <= GRANT;
                    end
                    GRANT: begin
                        // A request arriving with the completing hit is
                        // latched immediately instead of being lost.
                        if (dport_hit) begin
                            if (new_req[c]) begin
                                state[c] <= PEND;
                                wen[c]   <= Mem_Write[c];
                                ren[c]   <= Mem_Read[c] && !Mem_Write[c];
                            end else begin
                                state[c] <= IDLE;
                                wen[c]   <= 1'b0;
                                ren[c]   <= 1'b0;
                            end
                        end
                    end
                    default: state[c] <= IDLE;
                endcase
            end
            if (|arb_gnt) sel <= arb_idx;
            if (any_grant && dport_hit) ptr <= ptr_next;
        end
    end

    // Route the shared port hit back to the granted core.
    always_comb begin
        dhit = '0;
        for (int c = 0; c < NCH; c++) begin
            dhit[c] = dport_hit && any_grant && (sel == SELW'(c));
        end
    end

    assign dmemREN   = ren;
    assign dmemWEN   = wen;
    assign imemREN   = ~halt;
    assign dport_ren = any_grant && ren[sel];
    assign dport_wen = any_grant && wen[sel];
    assign dport_sel = sel;

`ifdef RU_WATCHDOG_EN
    localparam int WDW = $clog2(WD_LIMIT + 1);
    logic [WDW-1:0] wd_cnt;
    logic           wd_flag;

    // Count stalled grant cycles; the flag is sticky until reset and
    // does not abort the grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else if (|arb_gnt) begin
            wd_cnt <= '0;
        end else if (any_grant && !dport_hit) begin
            if (wd_cnt == WDW'(WD_LIMIT - 1)) wd_flag <= 1'b1;
            if (wd_cnt != WDW'(WD_LIMIT))     wd_cnt  <= wd_cnt + 1'b1;
        end
    end

    assign wd_err = wd_flag;
`else
    assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_request_unit.sv
// Directed bench for multi_request_unit with two cores and an 8-cycle
// watchdog limit. Inputs change on the falling edge; outputs are checked
// on the falling edge, away from the active rising edge.
module tb_multi_request_unit;

    localparam int NCH      = 2;
    localparam int WD_LIMIT = 8;
`ifdef RU_WATCHDOG_EN
    localparam logic [31:0] WD_EXP = 32'd1;
`else
    localparam logic [31:0] WD_EXP = 32'd0;
`endif

    logic           CLK = 1'b0;
    logic           RST;
    logic [NCH-1:0] ihit;
    logic [NCH-1:0] Mem_Read;
    logic [NCH-1:0] Mem_Write;
    logic [NCH-1:0] halt;
    logic           dport_hit;
    logic [NCH-1:0] dhit;
    logic [NCH-1:0] dmemREN;
    logic [NCH-1:0] dmemWEN;
    logic [NCH-1:0] imemREN;
    logic           dport_ren;
    logic           dport_wen;
    logic [0:0]     dport_sel;
    logic           wd_err;

    int checks   = 0;
    int failures = 0;

    multi_request_unit #(.NCH(NCH), .WD_LIMIT(WD_LIMIT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ihit      (ihit),
        .Mem_Read  (Mem_Read),
        .Mem_Write (Mem_Write),
        .halt      (halt),
        .dport_hit (dport_hit),
        .dhit      (dhit),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .imemREN   (imemREN),
        .dport_ren (dport_ren),
        .dport_wen (dport_wen),
        .dport_sel (dport_sel),
        .wd_err    (wd_err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; ihit = 2'b11; Mem_Read = 2'b11; Mem_Write = 2'b00;
        halt = 2'b00; dport_hit = 1'b0;

        // Reset held two cycles while requests are offered.
        step(); step();
        check("rst_ren",    32'(dmemREN),   32'h0);
        check("rst_wen",    32'(dmemWEN),   32'h0);
        check("rst_pren",   32'(dport_ren), 32'h0);
        check("rst_pwen",   32'(dport_wen), 32'h0);
        check("rst_sel",    32'(dport_sel), 32'h0);
        check("rst_wd",     32'(wd_err),    32'h0);
        check("rst_imem",   32'(imemREN),   32'h3);
        dport_hit = 1'b1; #1;
        check("rst_dhit",   32'(dhit),      32'h0);
        dport_hit = 1'b0;
        RST = 1'b0; ihit = 2'b00; Mem_Read = 2'b00;
        step();
        check("idle_ren",   32'(dmemREN),   32'h0);

        // Single read on core 0.
        ihit = 2'b01; Mem_Read = 2'b01;
        step();
        check("t1_pend_ren",  32'(dmemREN),   32'h1);
        check("t1_pend_port", 32'(dport_ren), 32'h0);
        ihit = 2'b00; Mem_Read = 2'b00;
        step();
        check("t1_gnt_ren",   32'(dport_ren), 32'h1);
        check("t1_gnt_sel",   32'(dport_sel), 32'h0);
        check("t1_gnt_dhit",  32'(dhit),      32'h0);
        step(); step();
        dport_hit = 1'b1; #1;
        check("t1_dhit",      32'(dhit),      32'h1);
        step();
        dport_hit = 1'b0;
        check("t1_done_ren",  32'(dmemREN),   32'h0);
        check("t1_done_port", 32'(dport_ren), 32'h0);

        // Reset returns the pointer to 0 before contention.
        RST = 1'b1; step(); RST = 1'b0;

        // Both cores write at the same edge.
        ihit = 2'b11; Mem_Write = 2'b11;
        step();
        check("t2_pend_wen",  32'(dmemWEN),   32'h3);
        check("t2_pend_port", 32'(dport_wen), 32'h0);
        ihit = 2'b00; Mem_Write = 2'b00;
        step();
        check("t2_g0_wen",    32'(dport_wen), 32'h1);
        check("t2_g0_sel",    32'(dport_sel), 32'h0);
        dport_hit = 1'b1; #1;
        check("t2_g0_dhit",   32'(dhit),      32'h1);
        step();
        dport_hit = 1'b0;
        check("t2_bubble",    32'(dport_wen), 32'h0);
        check("t2_bub_wen",   32'(dmemWEN),   32'h2);
        check("t2_bub_sel",   32'(dport_sel), 32'h0);
        step();
        check("t2_g1_wen",    32'(dport_wen), 32'h1);
        check("t2_g1_sel",    32'(dport_sel), 32'h1);
        dport_hit = 1'b1; #1;
        check("t2_g1_dhit",   32'(dhit),      32'h2);
        step();
        dport_hit = 1'b0;
        check("t2_done_wen",  32'(dmemWEN),   32'h0);
        check("t2_done_port", 32'(dport_wen), 32'h0);

        // Core 0 read+write (write wins), core 1 read; pointer is back at 0.
        ihit = 2'b11; Mem_Read = 2'b11; Mem_Write = 2'b01;
        step();
        check("t3_wen",       32'(dmemWEN),   32'h1);
        check("t3_ren",       32'(dmemREN),   32'h2);
        ihit = 2'b00; Mem_Read = 2'b00; Mem_Write = 2'b00;
        step();
        check("t3_sel",       32'(dport_sel), 32'h0);
        check("t3_pwen",      32'(dport_wen), 32'h1);
        check("t3_pren",      32'(dport_ren), 32'h0);

        // Completing hit on core 0 together with a new read.
        dport_hit = 1'b1; ihit = 2'b01; Mem_Read = 2'b01; #1;
        check("t4_dhit",      32'(dhit),      32'h1);
        step();
        dport_hit = 1'b0; ihit = 2'b00; Mem_Read = 2'b00;
        check("t4_ren",       32'(dmemREN),   32'h3);
        check("t4_wen",       32'(dmemWEN),   32'h0);
        check("t4_bubble",    32'(dport_ren), 32'h0);
        step();
        check("t4_g1_sel",    32'(dport_sel), 32'h1);
        check("t4_g1_ren",    32'(dport_ren), 32'h1);

        // Spurious write ihit and halt on core 1 while it holds the grant.
        ihit = 2'b10; Mem_Write = 2'b10; halt = 2'b10; #1;
        check("t5_imem",      32'(imemREN),   32'h1);
        step();
        ihit = 2'b00; Mem_Write = 2'b00;
        check("t5_wen",       32'(dmemWEN),   32'h0);
        check("t5_ren",       32'(dmemREN),   32'h3);
        check("t5_pren",      32'(dport_ren), 32'h1);
        check("t5_pwen",      32'(dport_wen), 32'h0);
        check("t5_sel",       32'(dport_sel), 32'h1);
        dport_hit = 1'b1; #1;
        check("t5_dhit",      32'(dhit),      32'h2);
        step();
        dport_hit = 1'b0;
        check("t5_done_ren",  32'(dmemREN),   32'h1);
        check("t5_bubble",    32'(dport_ren), 32'h0);

        // A halted core's new request is not latched; core 0 gets the port.
        ihit = 2'b10; Mem_Read = 2'b10;
        step();
        ihit = 2'b00; Mem_Read = 2'b00; halt = 2'b00;
        check("t6_sel",       32'(dport_sel), 32'h0);
        check("t6_pren",      32'(dport_ren), 32'h1);
        check("t6_ren",       32'(dmemREN),   32'h1);

        // Core 0 now holds the grant with no port hit.
        repeat (7) step();
        check("wd_below",     32'(wd_err),    32'h0);
        step();
        check("wd_limit",     32'(wd_err),    WD_EXP);
        check("wd_no_abort",  32'(dport_ren), 32'h1);
        dport_hit = 1'b1;
        step();
        dport_hit = 1'b0;
        check("wd_sticky",    32'(wd_err),    WD_EXP);
        check("wd_done_ren",  32'(dmemREN),   32'h0);

        // Reset in the middle of a granted write.
        ihit = 2'b10; Mem_Write = 2'b10;
        step();
        ihit = 2'b00; Mem_Write = 2'b00;
        step();
        check("t7_pwen",      32'(dport_wen), 32'h1);
        check("t7_sel",       32'(dport_sel), 32'h1);
        RST = 1'b1;
        step();
        check("t7_rst_pwen",  32'(dport_wen), 32'h0);
        check("t7_rst_wen",   32'(dmemWEN),   32'h0);
        check("t7_rst_sel",   32'(dport_sel), 32'h0);
        check("t7_rst_wd",    32'(wd_err),    32'h0);
        RST = 1'b0;
        step();
        check("t7_after",     32'(dport_wen), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
